// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// riscv_pkg    : shared core constants (register index width).
// hazard_ctrl_if: bundles every hazard-unit signal except clock and reset.
//   master modport - pipeline side: drives stage status, receives controls
//   slave modport  - hazard_ctrl: receives stage status, drives controls
//   status : id_rs1/id_rs2 (+ _used), ex_rd, ex_mem_read, ex_branch_taken,
//            dmem_req, dmem_ready, imem_ready
//   control: pc_en, *_en / *_clr per pipeline register, stall_cnt,
//            flush_cnt, mem_timeout
// ---------------------------------------------------------------------------
package riscv_pkg;
  localparam int reg_width = 5;
endpackage

interface hazard_ctrl_if #(
  parameter int REG_W = riscv_pkg::reg_width
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             imem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_clr;
  logic             idex_clr;
  logic             exmem_clr;
  logic             memwb_clr;
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;
  logic             mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_branch_taken, dmem_req, dmem_ready, imem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, memwb_clr,
           stall_cnt, flush_cnt, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_branch_taken, dmem_req, dmem_ready, imem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, memwb_clr,
           stall_cnt, flush_cnt, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl: pipeline hazard controller for a 5-stage RISC-V core.
// Resolves load-use hazards, taken-branch flushes, instruction-fetch misses
// and data-memory stalls into PC / pipeline-register enable and clear
// controls. A data-memory wait that lasts WAIT_TIMEOUT cycles locks the unit
// in an error state until reset.
//   CLK  : single clock, all state on the rising edge
//   RSTn : synchronous active-low reset
//   bus  : hazard_ctrl_if.slave (stage status in, pipeline controls out)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 255
) (
  input logic         CLK,
  input logic         RSTn,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  state_t      cur_state;
  logic [31:0] wait_cnt;
  logic        lu;
  logic        ms;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_clr;
  logic        idex_clr;
  logic        exmem_clr;
  logic        memwb_clr;
  logic        flush_apply;

  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // While reset is held the outputs behave as RUN, even though the register
  // only returns to RUN on the next edge.
  assign cur_state = RSTn ? state : RUN;

  // x0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign lu = bus.ex_mem_read && (bus.ex_rd != '0) &&
              ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
               (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));

  assign ms = bus.dmem_req && !bus.dmem_ready;

  // State register
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Wait counter: zero while running, counts every MEM_WAIT cycle
  always_ff @(posedge CLK) begin
    if (!RSTn || (state == RUN)) begin
      wait_cnt <= '0;
    end else if (state == MEM_WAIT) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

  // Next-state logic. The timeout compares against WAIT_TIMEOUT-1 because the
  // count updates on the same edge that would enter ERROR.
  always_comb begin
    next_state = state;
    unique case (state)
      RUN: begin
        if (ms) begin
          next_state = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!ms) begin
          next_state = RUN;
        end else if (wait_cnt >= 32'(WAIT_TIMEOUT - 1)) begin
          next_state = ERROR;
        end
      end
      ERROR: begin
        next_state = ERROR;
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // Output logic: only the highest-priority active condition shapes the
  // controls. A memory stall outranks branch and load-use, so their effect is
  // naturally deferred until the memory access completes.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_clr    = 1'b0;
    idex_clr    = 1'b0;
    exmem_clr   = 1'b0;
    memwb_clr   = 1'b0;
    flush_apply = 1'b0;
    if (cur_state == ERROR) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ms) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_clr = 1'b1;
    end else if (bus.ex_branch_taken) begin
      ifid_clr    = 1'b1;
      idex_clr    = 1'b1;
      flush_apply = 1'b1;
    end else if (lu) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
    end else if (!bus.imem_ready) begin
      pc_en    = 1'b0;
      ifid_clr = 1'b1;
    end
  end

  // Saturating performance counters; ERROR freezes the PC but is not a stall
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && (state != ERROR) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush_apply && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_clr    = ifid_clr;
  assign bus.idex_clr    = idex_clr;
  assign bus.exmem_clr   = exmem_clr;
  assign bus.memwb_clr   = memwb_clr;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.mem_timeout = (cur_state == ERROR);

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl.
// Two instances share one stimulus stream: dut_a (default timeout) and
// dut_b (WAIT_TIMEOUT=4). Each stimulus step pushes its expected controls
// and counters; a monitor pops them mid-cycle and compares against the
// selected instance.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  typedef struct {
    logic       rstn;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       dreq;
    logic       drdy;
    logic       irdy;
  } stim_t;

  typedef struct {
    string       tag;
    logic [8:0]  ctl;
    logic        to;
    logic [31:0] stall;
    logic [31:0] flush;
    bit          sel;
    bit          chk_cnt;
  } exp_t;

  // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem, memwb clears}
  localparam logic [8:0] C_RUN = 9'b11111_0000;
  localparam logic [8:0] C_MS  = 9'b00001_0001;
  localparam logic [8:0] C_BR  = 9'b11111_1100;
  localparam logic [8:0] C_LU  = 9'b00111_0100;
  localparam logic [8:0] C_IM  = 9'b01111_1000;
  localparam logic [8:0] C_ERR = 9'b00000_0000;

  logic  clk;
  logic  rstn;
  stim_t cur;
  exp_t  sbq[$];
  int    compared;
  int    mismatched;

  hazard_ctrl_if bus_a ();
  hazard_ctrl_if bus_b ();

  hazard_ctrl dut_a (.CLK(clk), .RSTn(rstn), .bus(bus_a));
  hazard_ctrl #(.WAIT_TIMEOUT(4)) dut_b (.CLK(clk), .RSTn(rstn), .bus(bus_b));

  assign rstn                  = cur.rstn;
  assign bus_a.id_rs1          = cur.rs1;
  assign bus_a.id_rs2          = cur.rs2;
  assign bus_a.id_rs1_used     = cur.u1;
  assign bus_a.id_rs2_used     = cur.u2;
  assign bus_a.ex_rd           = cur.rd;
  assign bus_a.ex_mem_read     = cur.mr;
  assign bus_a.ex_branch_taken = cur.br;
  assign bus_a.dmem_req        = cur.dreq;
  assign bus_a.dmem_ready      = cur.drdy;
  assign bus_a.imem_ready      = cur.irdy;
  assign bus_b.id_rs1          = cur.rs1;
  assign bus_b.id_rs2          = cur.rs2;
  assign bus_b.id_rs1_used     = cur.u1;
  assign bus_b.id_rs2_used     = cur.u2;
  assign bus_b.ex_rd           = cur.rd;
  assign bus_b.ex_mem_read     = cur.mr;
  assign bus_b.ex_branch_taken = cur.br;
  assign bus_b.dmem_req        = cur.dreq;
  assign bus_b.dmem_ready      = cur.drdy;
  assign bus_b.imem_ready      = cur.irdy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t idleS(input logic r);
    stim_t s;
    s.rstn = r;
    s.rs1  = 5'd0;
    s.rs2  = 5'd0;
    s.u1   = 1'b0;
    s.u2   = 1'b0;
    s.rd   = 5'd0;
    s.mr   = 1'b0;
    s.br   = 1'b0;
    s.dreq = 1'b0;
    s.drdy = 1'b1;
    s.irdy = 1'b1;
    return s;
  endfunction

  function automatic stim_t luS(input logic r);
    stim_t s;
    s     = idleS(r);
    s.mr  = 1'b1;
    s.rd  = 5'd5;
    s.rs1 = 5'd5;
    s.u1  = 1'b1;
    return s;
  endfunction

  function automatic stim_t msS(input logic r, input logic rdy);
    stim_t s;
    s      = idleS(r);
    s.dreq = 1'b1;
    s.drdy = rdy;
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of stimulus just after the falling edge and queues what
  // the selected instance must show during that cycle.
  task automatic applyStimulus(input string tag, input stim_t s,
                               input logic [8:0] ctl, input logic to,
                               input logic [31:0] stall, input logic [31:0] flush,
                               input bit sel, input bit chk_cnt);
    exp_t e;
    @(negedge clk);
    cur       = s;
    e.tag     = tag;
    e.ctl     = ctl;
    e.to      = to;
    e.stall   = stall;
    e.flush   = flush;
    e.sel     = sel;
    e.chk_cnt = chk_cnt;
    sbq.push_back(e);
  endtask

  // Monitor: samples mid-cycle, well away from the rising edge
  initial begin
    exp_t        e;
    logic [8:0]  ctl;
    logic        to;
    logic [31:0] sc;
    logic [31:0] fc;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.sel) begin
          ctl = {bus_b.pc_en, bus_b.ifid_en, bus_b.idex_en, bus_b.exmem_en,
                 bus_b.memwb_en, bus_b.ifid_clr, bus_b.idex_clr,
                 bus_b.exmem_clr, bus_b.memwb_clr};
          to  = bus_b.mem_timeout;
          sc  = bus_b.stall_cnt;
          fc  = bus_b.flush_cnt;
        end else begin
          ctl = {bus_a.pc_en, bus_a.ifid_en, bus_a.idex_en, bus_a.exmem_en,
                 bus_a.memwb_en, bus_a.ifid_clr, bus_a.idex_clr,
                 bus_a.exmem_clr, bus_a.memwb_clr};
          to  = bus_a.mem_timeout;
          sc  = bus_a.stall_cnt;
          fc  = bus_a.flush_cnt;
        end
        checkOutput({e.tag, ".ctl"}, 32'(ctl), 32'(e.ctl));
        checkOutput({e.tag, ".timeout"}, 32'(to), 32'(e.to));
        if (e.chk_cnt) begin
          checkOutput({e.tag, ".stall"}, sc, e.stall);
          checkOutput({e.tag, ".flush"}, fc, e.flush);
        end
      end
    end
  end

  initial begin
    stim_t s;
    compared   = 0;
    mismatched = 0;
    cur        = idleS(1'b0);
    repeat (2) @(posedge clk);

    // Reset behaviour: outputs follow RUN with live inputs
    applyStimulus("rst_idle", idleS(1'b0), C_RUN, 1'b0, 0, 0, 1'b0, 1'b1);
    applyStimulus("rst_lu",   luS(1'b0),   C_LU,  1'b0, 0, 0, 1'b0, 1'b1);
    applyStimulus("idle",     idleS(1'b1), C_RUN, 1'b0, 0, 0, 1'b0, 1'b1);

    // Load-use, then the same load into x0
    applyStimulus("lu",       luS(1'b1),   C_LU,  1'b0, 0, 0, 1'b0, 1'b1);
    applyStimulus("lu_after", idleS(1'b1), C_RUN, 1'b0, 1, 0, 1'b0, 1'b1);
    s = luS(1'b1); s.rd = 5'd0; s.rs1 = 5'd0;
    applyStimulus("lu_rd0",   s,           C_RUN, 1'b0, 1, 0, 1'b0, 1'b1);

    // Taken branch beats load-use
    s = luS(1'b1); s.br = 1'b1;
    applyStimulus("br_lu",    s,           C_BR,  1'b0, 1, 0, 1'b0, 1'b1);
    applyStimulus("br_after", idleS(1'b1), C_RUN, 1'b0, 1, 1, 1'b0, 1'b1);

    // Three-cycle memory stall; branch+LU ignored while waiting
    applyStimulus("ms1",      msS(1'b1, 1'b0), C_MS, 1'b0, 1, 1, 1'b0, 1'b1);
    applyStimulus("ms2",      msS(1'b1, 1'b0), C_MS, 1'b0, 2, 1, 1'b0, 1'b1);
    s = msS(1'b1, 1'b0); s.br = 1'b1; s.mr = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
    applyStimulus("ms3_br",   s,               C_MS, 1'b0, 3, 1, 1'b0, 1'b1);
    applyStimulus("ms_exit",  msS(1'b1, 1'b1), C_RUN, 1'b0, 4, 1, 1'b0, 1'b1);
    applyStimulus("ms_post",  idleS(1'b1),     C_RUN, 1'b0, 4, 1, 1'b0, 1'b1);

    // Exit cycle of a wait evaluates the branch like RUN
    applyStimulus("ms4",      msS(1'b1, 1'b0), C_MS, 1'b0, 4, 1, 1'b0, 1'b1);
    s = msS(1'b1, 1'b1); s.br = 1'b1;
    applyStimulus("exit_br",  s,               C_BR, 1'b0, 5, 1, 1'b0, 1'b1);

    // Fetch miss alone, then combined with load-use
    s = idleS(1'b1); s.irdy = 1'b0;
    applyStimulus("imem",     s,               C_IM, 1'b0, 5, 2, 1'b0, 1'b1);
    s = luS(1'b1); s.irdy = 1'b0;
    applyStimulus("imem_lu",  s,               C_LU, 1'b0, 6, 2, 1'b0, 1'b1);

    // rs2 match, then matching indices that are not read
    s = idleS(1'b1); s.mr = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.rs2 = 5'd7; s.u2 = 1'b1;
    applyStimulus("lu_rs2",   s,               C_LU,  1'b0, 7, 2, 1'b0, 1'b1);
    s.u2 = 1'b0;
    applyStimulus("unused",   s,               C_RUN, 1'b0, 8, 2, 1'b0, 1'b1);

    // Stall counter saturation
    @(negedge clk);
    force dut_a.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut_a.stall_cnt_q;
    applyStimulus("sat1", luS(1'b1),   C_LU,  1'b0, 32'hFFFF_FFFE, 2, 1'b0, 1'b1);
    applyStimulus("sat2", luS(1'b1),   C_LU,  1'b0, 32'hFFFF_FFFF, 2, 1'b0, 1'b1);
    applyStimulus("sat3", luS(1'b1),   C_LU,  1'b0, 32'hFFFF_FFFF, 2, 1'b0, 1'b1);
    applyStimulus("sat4", idleS(1'b1), C_RUN, 1'b0, 32'hFFFF_FFFF, 2, 1'b0, 1'b1);

    // Timeout on the short-timeout instance
    applyStimulus("t_rst", idleS(1'b0), C_RUN, 1'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("t_ms%0d", i), msS(1'b1, 1'b0), C_MS, 1'b0, 32'(i), 0,
                    1'b1, 1'b1);
    end
    applyStimulus("t_err",    msS(1'b1, 1'b0), C_ERR, 1'b1, 5, 0, 1'b1, 1'b1);
    applyStimulus("t_sticky", idleS(1'b1),     C_ERR, 1'b1, 5, 0, 1'b1, 1'b1);
    applyStimulus("t_rst_er", idleS(1'b0),     C_RUN, 1'b0, 5, 0, 1'b1, 1'b1);
    applyStimulus("t_clean",  idleS(1'b1),     C_RUN, 1'b0, 0, 0, 1'b1, 1'b1);

    // Reset in the middle of a wait
    applyStimulus("w_ms0",  msS(1'b1, 1'b0), C_MS,  1'b0, 0, 0, 1'b1, 1'b1);
    applyStimulus("w_ms1",  msS(1'b1, 1'b0), C_MS,  1'b0, 1, 0, 1'b1, 1'b1);
    applyStimulus("w_rst",  msS(1'b0, 1'b0), C_MS,  1'b0, 2, 0, 1'b1, 1'b1);
    applyStimulus("w_post", idleS(1'b1),     C_RUN, 1'b0, 0, 0, 1'b1, 1'b1);

    @(negedge clk);
    #5;
    checkOutput("sb_drain", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
